// File: rtl/mod_aud_fm_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_aud_fm_seq_if
// Description : Command-push and FM synth write-port bundle for mod_aud_fm_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_aud_fm_seq_if;
    logic        cmdValid;
    logic [7:0]  cmdDelay;
    logic [3:0]  cmdChan;
    logic [2:0]  cmdReg;
    logic [31:0] cmdData;
    logic        cmdReady;

    logic [31:0] busAddr;
    logic [31:0] busOutData;
    logic [4:0]  busOpm;
    logic [1:0]  busOK;

    // master: the sequencer (accepts commands, drives the synth bus)
    modport master (
        input  cmdValid, cmdDelay, cmdChan, cmdReg, cmdData, busOK,
        output cmdReady, busAddr, busOutData, busOpm
    );

    // slave: command producer and FM synth side
    modport slave (
        output cmdValid, cmdDelay, cmdChan, cmdReg, cmdData, busOK,
        input  cmdReady, busAddr, busOutData, busOpm
    );
endinterface
`default_nettype wire

// File: rtl/mod_aud_fm_seq.sv
`default_nettype none
// ============================================================================
// Module      : mod_aud_fm_seq
// Description : Timed FM-synth register write sequencer with command FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_aud_fm_seq #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] TICK_INC   = 16'h0029,
    parameter logic [4:0]  SEQ_OPM_WR = 5'h12
) (
    input  wire                           clock,
    input  wire                           reset,
    input  wire                           flush,
    mod_aud_fm_seq_if.master              bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
    output logic                          busy,
    output logic                          fault
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 47;

    localparam logic [CW-1:0] c_full      = CW'(FIFO_DEPTH);
    localparam logic [31:0]   c_bus_base  = 32'h0008_C000;
    localparam logic [1:0]    c_rsp_ready = 2'b00;
    localparam logic [1:0]    c_rsp_ok    = 2'b01;
    localparam logic [1:0]    c_rsp_fault = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     acc_q, acc_d;
    logic            w_tick;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [EW-1:0]   w_head;
    logic            w_push, w_pop, w_ready;

    logic [7:0]      delay_q, delay_d;
    logic [3:0]      act_chan_q, act_chan_d;
    logic [2:0]      act_rsel_q, act_rsel_d;
    logic [31:0]     act_data_q, act_data_d;

    logic [31:0]     bus_addr_q, bus_addr_d;
    logic [31:0]     bus_data_q, bus_data_d;
    logic [4:0]      bus_opm_q, bus_opm_d;
    logic            fault_q, fault_d;

    function automatic logic [31:0] synth_addr(input logic [3:0] chan, input logic [2:0] rsel);
        return c_bus_base | {23'd0, chan, 5'd0} | {27'd0, rsel, 2'd0};
    endfunction

    // Fractional tick: carry out of the 16-bit phase accumulator.
    assign {w_tick, acc_d} = {1'b0, acc_q} + {1'b0, TICK_INC};

    assign w_ready = (count_q != c_full);
    assign w_push  = bus.cmdValid && w_ready && !flush;
    assign w_head  = mem_q[rd_ptr_q];

    // FIFO storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {bus.cmdDelay, bus.cmdChan, bus.cmdReg, bus.cmdData};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (w_push && !w_pop)      count_d = count_q + 1'b1;
            else if (w_pop && !w_push) count_d = count_q - 1'b1;
        end
    end

    // Bus outputs are computed alongside the next state so they are registered
    // on the same edge that enters ISSUE or RELEASE.
    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        act_chan_d = act_chan_q;
        act_rsel_d = act_rsel_q;
        act_data_d = act_data_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        bus_opm_d  = bus_opm_q;
        fault_d    = fault_q;
        w_pop      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if ((count_q != '0) && !flush) begin
                    w_pop      = 1'b1;
                    delay_d    = w_head[46:39];
                    act_chan_d = w_head[38:35];
                    act_rsel_d = w_head[34:32];
                    act_data_d = w_head[31:0];
                    if (w_head[46:39] != 8'd0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d    = ST_ISSUE;
                        bus_addr_d = synth_addr(w_head[38:35], w_head[34:32]);
                        bus_data_d = w_head[31:0];
                        bus_opm_d  = SEQ_OPM_WR;
                    end
                end
            end

            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (w_tick) begin
                    if (delay_q == 8'd1) begin
                        state_d    = ST_ISSUE;
                        bus_addr_d = synth_addr(act_chan_q, act_rsel_q);
                        bus_data_d = act_data_q;
                        bus_opm_d  = SEQ_OPM_WR;
                    end else begin
                        delay_d = delay_q - 8'd1;
                    end
                end
            end

            ST_ISSUE: begin
                if ((bus.busOK == c_rsp_ok) || (bus.busOK == c_rsp_fault)) begin
                    state_d    = ST_RELEASE;
                    bus_addr_d = '0;
                    bus_opm_d  = '0;
                    if (bus.busOK == c_rsp_fault) fault_d = 1'b1;
                end
            end

            ST_RELEASE: begin
                if (bus.busOK == c_rsp_ready) state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                bus_opm_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            delay_q    <= '0;
            act_chan_q <= '0;
            act_rsel_q <= '0;
            act_data_q <= '0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_opm_q  <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            delay_q    <= delay_d;
            act_chan_q <= act_chan_d;
            act_rsel_q <= act_rsel_d;
            act_data_q <= act_data_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            bus_opm_q  <= bus_opm_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.cmdReady   = w_ready;
    assign bus.busAddr    = bus_addr_q;
    assign bus.busOutData = bus_data_q;
    assign bus.busOpm     = bus_opm_q;
    assign fifoCount      = count_q;
    assign busy           = (state_q != ST_IDLE) || (count_q != '0);
    assign fault          = fault_q;

endmodule
`default_nettype wire
